// File: rtl/stk_mc_pkg.sv
// Shared types and default sizing for the stk_mc multi-channel stack engine.
package stk_mc_pkg;

  typedef enum logic [2:0] {
    NOP     = 3'd0,
    PUSH    = 3'd1,
    POP     = 3'd2,
    PUSHPOP = 3'd3,
    CLR     = 3'd4
  } opcode_t;

  localparam int CH_N_DEF  = 4;
  localparam int W_DEF     = 128;
  localparam int DEPTH_DEF = 16;

endpackage

// File: rtl/stk_mc_arb.sv
// Round-robin arbiter: one-hot grant searched from r_prio, which then moves
// to the channel after the winner.
module stk_mc_arb #(
  parameter int CH_N = 4,
  localparam int PW  = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_N-1:0] i_req,
  input  logic            i_advance,
  output logic [CH_N-1:0] o_gnt
);

  logic [PW-1:0] r_prio;
  logic [PW-1:0] w_prio_nxt;
  logic          w_found;
  int            w_idx;

  always_comb begin
    o_gnt      = '0;
    w_prio_nxt = r_prio;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < CH_N; i++) begin
      w_idx = (int'(r_prio) + i) % CH_N;
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        w_prio_nxt   = PW'((w_idx + 1) % CH_N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= '0;
    end else if (i_advance && w_found) begin
      r_prio <= w_prio_nxt;
    end
  end

endmodule

// File: rtl/stk_mc.sv
// Multi-channel stack engine: CH_N private LIFOs in one shared array, one command
// per cycle, registered response. Define STK_MC_PUSHPOP_EN to implement PUSHPOP.
module stk_mc
  import stk_mc_pkg::*;
#(
  parameter int CH_N  = CH_N_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  opcode_t [CH_N-1:0]        i_cmd_opcode,
  input  logic [CH_N-1:0][W-1:0]    i_cmd_dat,
  output logic [CH_N-1:0]           o_cmd_ack,
  output logic [CH_N-1:0]           o_rsp_vld,
  output logic [W-1:0]              o_rsp_dat,
  output logic                      o_rsp_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(CH_N * DEPTH);
  localparam int SW = (CH_N > 1) ? $clog2(CH_N) : 1;

  logic [W-1:0]  r_mem [CH_N*DEPTH];
  logic [CW-1:0] r_cnt [CH_N];

  logic [CH_N-1:0] w_req;
  logic [CH_N-1:0] w_gnt;
  logic [CH_N-1:0] w_ack;
  logic [SW-1:0]   w_sel;
  opcode_t         w_op;
  logic [W-1:0]    w_dat;
  logic [CW-1:0]   w_cnt;
  logic [AW-1:0]   w_push_addr;
  logic [AW-1:0]   w_top_addr;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic            w_cnt_we;
  logic [CW-1:0]   w_cnt_nxt;
  logic [W-1:0]    w_rsp_dat;
  logic            w_rsp_err;

  always_comb begin
    for (int c = 0; c < CH_N; c++) begin
      w_req[c] = (i_cmd_opcode[c] != NOP);
    end
  end

  stk_mc_arb #(.CH_N(CH_N)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_advance(!rst),
    .o_gnt    (w_gnt)
  );

  // Grants are suppressed during reset so nothing is consumed or answered.
  assign w_ack     = rst ? '0 : w_gnt;
  assign o_cmd_ack = w_ack;

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < CH_N; c++) begin
      if (w_ack[c]) w_sel = SW'(c);
    end
    w_op        = i_cmd_opcode[w_sel];
    w_dat       = i_cmd_dat[w_sel];
    w_cnt       = r_cnt[w_sel];
    // Each channel owns the address window [sel*DEPTH, sel*DEPTH+DEPTH-1].
    w_push_addr = AW'(int'(w_sel) * DEPTH + int'(w_cnt));
    w_top_addr  = AW'(int'(w_sel) * DEPTH + int'(w_cnt) - 1);
    w_we        = 1'b0;
    w_waddr     = w_push_addr;
    w_cnt_we    = 1'b0;
    w_cnt_nxt   = w_cnt;
    w_rsp_dat   = '0;
    w_rsp_err   = 1'b0;
    if (|w_ack) begin
      case (w_op)
        NOP: ;
        PUSH: begin
          if (w_cnt < CW'(DEPTH)) begin
            w_we      = 1'b1;
            w_cnt_we  = 1'b1;
            w_cnt_nxt = w_cnt + CW'(1);
          end else begin
            w_rsp_err = 1'b1;
          end
        end
        POP: begin
          if (w_cnt != '0) begin
            w_rsp_dat = r_mem[w_top_addr];
            w_cnt_we  = 1'b1;
            w_cnt_nxt = w_cnt - CW'(1);
          end else begin
            w_rsp_err = 1'b1;
          end
        end
`ifdef STK_MC_PUSHPOP_EN
        PUSHPOP: begin
          if (w_cnt != '0) begin
            w_rsp_dat = r_mem[w_top_addr];
            w_we      = 1'b1;
            w_waddr   = w_top_addr;
          end else begin
            w_rsp_err = 1'b1;
          end
        end
`endif
        CLR: begin
          w_cnt_we  = 1'b1;
          w_cnt_nxt = '0;
        end
        default: w_rsp_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH_N; c++) r_cnt[c] <= '0;
    end else if (w_cnt_we) begin
      r_cnt[w_sel] <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rsp_vld <= '0;
      o_rsp_dat <= '0;
      o_rsp_err <= 1'b0;
    end else begin
      o_rsp_vld <= w_ack;
      o_rsp_dat <= w_rsp_dat;
      o_rsp_err <= w_rsp_err;
    end
  end

endmodule

// File: tb/tb_stk_mc.sv
// Directed bench for stk_mc (4 channels, 128-bit words, depth 16); PUSHPOP
// expectations follow STK_MC_PUSHPOP_EN.
module tb_stk_mc;
  import stk_mc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  opcode_t [3:0]        opc;
  logic [3:0][127:0]    dat;
  logic [3:0]           ack;
  logic [3:0]           vld;
  logic [127:0]         rdat;
  logic                 rerr;
  int                   n_checks = 0;
  int                   n_errors = 0;

  always #5 clk = ~clk;

  stk_mc #(.CH_N(4), .W(128), .DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_opcode(opc),
    .i_cmd_dat   (dat),
    .o_cmd_ack   (ack),
    .o_rsp_vld   (vld),
    .o_rsp_dat   (rdat),
    .o_rsp_err   (rerr)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: ack checked before the edge, the registered response just after it.
  task automatic tick(input string tag, input logic [3:0] e_ack, input logic [3:0] e_vld,
                      input logic [127:0] e_dat, input logic e_err);
    #1;
    check({tag, ".ack"}, {124'd0, ack}, {124'd0, e_ack});
    @(posedge clk);
    #1;
    check({tag, ".vld"}, {124'd0, vld}, {124'd0, e_vld});
    check({tag, ".dat"}, rdat, e_dat);
    check({tag, ".err"}, {127'd0, rerr}, {127'd0, e_err});
  endtask

  task automatic idle_all();
    for (int c = 0; c < 4; c++) begin
      opc[c] = NOP;
      dat[c] = '0;
    end
  endtask

  task automatic one(input string tag, input int ch, input opcode_t op, input logic [127:0] d,
                     input logic [127:0] e_dat, input logic e_err);
    idle_all();
    opc[ch] = op;
    dat[ch] = d;
    tick(tag, 4'(1 << ch), 4'(1 << ch), e_dat, e_err);
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    opc[0] = PUSH;
    tick("reset0", 4'b0000, 4'b0000, 128'd0, 1'b0);
    tick("reset1", 4'b0000, 4'b0000, 128'd0, 1'b0);
    rst = 1'b0;
    idle_all();
    tick("idle", 4'b0000, 4'b0000, 128'd0, 1'b0);

    // Basic LIFO on ch0
    one("lifo_push_a", 0, PUSH, 128'hA, 128'd0, 1'b0);
    one("lifo_push_b", 0, PUSH, 128'hB, 128'd0, 1'b0);
    one("lifo_pop_b", 0, POP, 128'd0, 128'hB, 1'b0);
    one("lifo_pop_a", 0, POP, 128'd0, 128'hA, 1'b0);

    // Underflow on ch2, then back-to-back push/pop
    one("uf_pop", 2, POP, 128'd0, 128'd0, 1'b1);
    one("uf_push5", 2, PUSH, 128'h5, 128'd0, 1'b0);
    one("uf_pop5", 2, POP, 128'd0, 128'h5, 1'b0);

    // Overflow on ch1
    for (int k = 1; k <= 16; k++) begin
      one("of_fill", 1, PUSH, 128'(k), 128'd0, 1'b0);
    end
    one("of_push17", 1, PUSH, 128'd17, 128'd0, 1'b1);
    one("of_pop16", 1, POP, 128'd0, 128'd16, 1'b0);

    // PUSHPOP on ch0 holding [1,2]
    one("pp_push1", 0, PUSH, 128'd1, 128'd0, 1'b0);
    one("pp_push2", 0, PUSH, 128'd2, 128'd0, 1'b0);
`ifdef STK_MC_PUSHPOP_EN
    one("pp_swap", 0, PUSHPOP, 128'd3, 128'd2, 1'b0);
    one("pp_pop3", 0, POP, 128'd0, 128'd3, 1'b0);
`else
    one("pp_rsvd", 0, PUSHPOP, 128'd3, 128'd0, 1'b1);
    one("pp_pop2", 0, POP, 128'd0, 128'd2, 1'b0);
`endif
    one("pp_pop1", 0, POP, 128'd0, 128'd1, 1'b0);

    // Reserved encoding and CLR
    one("rsvd5", 3, opcode_t'(3'd5), 128'h77, 128'd0, 1'b1);
    one("rsvd_pop", 3, POP, 128'd0, 128'd0, 1'b1);
    one("clr", 1, CLR, 128'd0, 128'd0, 1'b0);
    one("clr_pop", 1, POP, 128'd0, 128'd0, 1'b1);

    // Fairness from a fresh reset: 0,1,2,3,0,1,2 then ch0/ch3 alternate from 3
    idle_all();
    rst = 1'b1;
    tick("fair_rst", 4'b0000, 4'b0000, 128'd0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      opc[c] = PUSH;
      dat[c] = 128'(c + 16);
    end
    for (int k = 0; k < 7; k++) begin
      tick("fair_all", 4'(1 << (k % 4)), 4'(1 << (k % 4)), 128'd0, 1'b0);
    end
    opc[1] = NOP;
    opc[2] = NOP;
    tick("fair_03_a", 4'b1000, 4'b1000, 128'd0, 1'b0);
    tick("fair_03_b", 4'b0001, 4'b0001, 128'd0, 1'b0);
    tick("fair_03_c", 4'b1000, 4'b1000, 128'd0, 1'b0);
    tick("fair_03_d", 4'b0001, 4'b0001, 128'd0, 1'b0);
    idle_all();
    one("fair_pop3", 3, POP, 128'd0, 128'd19, 1'b0);

    // Reset mid-stream with ch3 holding a POP
    one("mr_push1", 3, PUSH, 128'h31, 128'd0, 1'b0);
    one("mr_push2", 3, PUSH, 128'h32, 128'd0, 1'b0);
    one("mr_push3", 3, PUSH, 128'h33, 128'd0, 1'b0);
    idle_all();
    opc[3] = POP;
    rst = 1'b1;
    tick("mr_rst", 4'b0000, 4'b0000, 128'd0, 1'b0);
    rst = 1'b0;
    tick("mr_pop", 4'b1000, 4'b1000, 128'd0, 1'b1);
    idle_all();
    tick("mr_idle", 4'b0000, 4'b0000, 128'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
